// File: rtl/spike_pattern_player.sv
// spike_pattern_player
//   Multi-batch spike-pattern memory with a playback sequencer that feeds the
//   SNN input layer one timestep at a time over a valid/ready handshake.
//
//   Memory word address = {timestep, batch}. A timestep's NUM_INPUTS-bit
//   vector is spread over NB = 2**SPIKE_PATTERN_BATCH_ADDR_WIDTH words.
//   Input i lives in batch i/BATCH_WIDTH, bit i%BATCH_WIDTH.
//
// Ports:
//   clk, rst        block clock, asynchronous active-high reset
//   wr_en           memory write strobe (accepted in every state)
//   wr_timestep     write timestep address
//   wr_batch        write batch address
//   wr_data         spike word to store
//   sim_time        number of timesteps to play (sampled on start)
//   loop_en         replay from timestep 0 after the last one (sampled on start)
//   start           single-cycle start pulse (ignored while busy)
//   abort           stop playback; beats every other transition
//   spikes_out      current timestep spike vector
//   spikes_valid    spikes_out valid
//   spikes_ready    network consumed the current timestep
//   cur_timestep    timestep currently fetched/presented
//   busy            sequencer not idle
//   done            single-cycle pulse at the end of each pass
module spike_pattern_player #(
  parameter int NUM_INPUTS                     = 9,
  parameter int BATCH_WIDTH                    = 32,
  parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 1,
  parameter int MAX_TIMESTEPS_BITS             = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [MAX_TIMESTEPS_BITS-1:0]             wr_timestep,
  input  logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] wr_batch,
  input  logic [BATCH_WIDTH-1:0]                    wr_data,
  input  logic [MAX_TIMESTEPS_BITS:0]               sim_time,
  input  logic                                      loop_en,
  input  logic                                      start,
  input  logic                                      abort,
  output logic [NUM_INPUTS-1:0]                     spikes_out,
  output logic                                      spikes_valid,
  input  logic                                      spikes_ready,
  output logic [MAX_TIMESTEPS_BITS-1:0]             cur_timestep,
  output logic                                      busy,
  output logic                                      done
);

  localparam int BAW   = SPIKE_PATTERN_BATCH_ADDR_WIDTH;
  localparam int TSW   = MAX_TIMESTEPS_BITS;
  localparam int NB    = 2 ** BAW;
  localparam int AW    = TSW + BAW;
  localparam int DEPTH = 2 ** AW;
  localparam int ASM_W = BATCH_WIDTH * NB;
  localparam int CNT_W = BAW + 1;

  generate
    if (NUM_INPUTS > ASM_W) begin : g_bad_width
      $error("spike_pattern_player: NUM_INPUTS exceeds BATCH_WIDTH * batches per timestep");
    end
    if (BAW < 1) begin : g_bad_batch
      $error("spike_pattern_player: SPIKE_PATTERN_BATCH_ADDR_WIDTH must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     fetch_cnt;     // 0..NB-1 issue reads, 1..NB capture
  logic [TSW:0]         sim_time_lat;
  logic                 loop_lat;
  logic [ASM_W-1:0]     asm_reg;
  logic [ASM_W-1:0]     asm_merged;
  logic [BATCH_WIDTH-1:0] rd_data;
  logic [AW-1:0]        rd_addr;
  logic                 last_fetch;
  logic                 last_ts;

  // Pattern memory: registered read, read-first on a same-address collision
  // because the read samples the array before the write's update lands.
  logic [BATCH_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_timestep, wr_batch}] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // The read port runs every cycle; only the captures in FETCH matter.
  assign rd_addr    = {cur_timestep, fetch_cnt[BAW-1:0]};
  assign last_fetch = (fetch_cnt == CNT_W'(NB));
  // Compared in TSW+1 bits so sim_time = 2**TSW ends at index 2**TSW-1.
  assign last_ts    = ({1'b0, cur_timestep} == (sim_time_lat - (TSW+1)'(1)));
  assign busy       = (state != S_IDLE);

  // Read data for batch k returns while fetch_cnt == k+1; splice it into the
  // assembly so the final batch can go straight to spikes_out on that edge.
  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign asm_merged[gi*BATCH_WIDTH +: BATCH_WIDTH] =
      (state == S_FETCH && fetch_cnt == CNT_W'(gi + 1)) ?
        rd_data : asm_reg[gi*BATCH_WIDTH +: BATCH_WIDTH];
  end

  // Batch bits above NUM_INPUTS are stored but never presented.
  if (ASM_W > NUM_INPUTS) begin : g_unused
    logic unused_hi_bits;
    assign unused_hi_bits = ^asm_merged[ASM_W-1:NUM_INPUTS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      fetch_cnt    <= '0;
      sim_time_lat <= '0;
      loop_lat     <= 1'b0;
      asm_reg      <= '0;
      spikes_out   <= '0;
      spikes_valid <= 1'b0;
      cur_timestep <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= S_IDLE;
        fetch_cnt    <= '0;
        spikes_out   <= '0;
        spikes_valid <= 1'b0;
        cur_timestep <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              sim_time_lat <= sim_time;
              loop_lat     <= loop_en;
              cur_timestep <= '0;
              fetch_cnt    <= '0;
              if (sim_time == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            asm_reg <= asm_merged;
            if (last_fetch) begin
              spikes_out   <= asm_merged[NUM_INPUTS-1:0];
              spikes_valid <= 1'b1;
              fetch_cnt    <= '0;
              state        <= S_PRESENT;
            end else begin
              fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
          end
          S_PRESENT: begin
            // spikes_valid is always high here, so ready alone is the handshake.
            if (spikes_ready) begin
              spikes_valid <= 1'b0;
              if (last_ts) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                cur_timestep <= cur_timestep + TSW'(1);
                state        <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            if (loop_lat && sim_time_lat != '0) begin
              cur_timestep <= '0;
              fetch_cnt    <= '0;
              state        <= S_FETCH;
            end else begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_pattern_player.sv
// Testbench for spike_pattern_player: table-driven pattern playback plus
// hand-written multi-cycle sequences, with a scoreboard of expected
// {spike vector, timestep} pairs popped on every valid/ready handshake.
module tb_spike_pattern_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_timestep;
  logic [0:0]  wr_batch;
  logic [31:0] wr_data;
  logic [8:0]  sim_time;
  logic        loop_en;
  logic        start;
  logic        abort;
  logic [8:0]  spikes_out;
  logic        spikes_valid;
  logic        spikes_ready;
  logic [7:0]  cur_timestep;
  logic        busy;
  logic        done;

  // Wide instance shares the write bus, sim_time, loop_en and abort.
  logic        m_start;
  logic        m_ready;
  logic [39:0] m_spikes;
  logic        m_valid;
  logic [7:0]  m_ts;
  logic        m_busy;
  logic        m_done;

  always #5 clk = ~clk;

  spike_pattern_player #(
    .NUM_INPUTS(9), .BATCH_WIDTH(32),
    .SPIKE_PATTERN_BATCH_ADDR_WIDTH(1), .MAX_TIMESTEPS_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_timestep(wr_timestep),
    .wr_batch(wr_batch), .wr_data(wr_data), .sim_time(sim_time),
    .loop_en(loop_en), .start(start), .abort(abort),
    .spikes_out(spikes_out), .spikes_valid(spikes_valid),
    .spikes_ready(spikes_ready), .cur_timestep(cur_timestep),
    .busy(busy), .done(done)
  );

  spike_pattern_player #(
    .NUM_INPUTS(40), .BATCH_WIDTH(32),
    .SPIKE_PATTERN_BATCH_ADDR_WIDTH(1), .MAX_TIMESTEPS_BITS(8)
  ) dut40 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_timestep(wr_timestep),
    .wr_batch(wr_batch), .wr_data(wr_data), .sim_time(sim_time),
    .loop_en(loop_en), .start(m_start), .abort(abort),
    .spikes_out(m_spikes), .spikes_valid(m_valid),
    .spikes_ready(m_ready), .cur_timestep(m_ts),
    .busy(m_busy), .done(m_done)
  );

  typedef struct {
    logic [8:0] spikes;
    logic [7:0] ts;
  } exp_t;

  typedef struct {
    logic [31:0] b0;
    logic [31:0] b1;
    logic [8:0]  spikes;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec_tab[6];

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  bit   valid_seen;
  bit   prev_done;
  bit   done_then_idle;
  logic [7:0] last_ts_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock: settle the handshake that the coming edge will see, then
  // advance to the next falling edge and sample the DUT.
  task automatic tick();
    exp_t e;
    if (spikes_valid && spikes_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_vector actual=0x%0h ts=%0d required=none", spikes_out, cur_timestep);
      end else begin
        e = exp_q.pop_front();
        chk("sb_spikes", {55'd0, spikes_out}, {55'd0, e.spikes});
        chk("sb_timestep", {56'd0, cur_timestep}, {56'd0, e.ts});
        $display("handshake ts=%0d spikes=0x%03h", cur_timestep, spikes_out);
      end
      last_ts_seen = cur_timestep;
    end
    @(posedge clk);
    @(negedge clk);
    if (done) done_cnt++;
    if (spikes_valid) valid_seen = 1'b1;
    if (prev_done && !busy) done_then_idle = 1'b1;
    prev_done = done;
  endtask

  task automatic wr(input logic [7:0] ts, input logic [0:0] b, input logic [31:0] d);
    wr_en = 1'b1; wr_timestep = ts; wr_batch = b; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] st, input logic lp);
    sim_time = st; loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!spikes_valid && n < budget) begin
      tick();
      n++;
    end
    chk(name, {63'd0, spikes_valid}, 64'd1);
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic write_defaults();
    for (int t = 0; t < 4; t++) begin
      wr(8'(t), 1'b0, (t % 2 == 0) ? 32'h0FA50FA5 : 32'hF05AF021);
      wr(8'(t), 1'b1, 32'h0);
    end
  endtask

  task automatic push_defaults(input int n);
    for (int t = 0; t < n; t++) begin
      exp_q.push_back('{(t % 2 == 0) ? 9'h1A5 : 9'h021, 8'(t)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] w;

    vec_tab[0] = '{32'h0FA50FA5, 32'h00000000, 9'h1A5};
    vec_tab[1] = '{32'hF05AF021, 32'h00000000, 9'h021};
    vec_tab[2] = '{32'hFFFFFFFF, 32'h00000000, 9'h1FF};
    vec_tab[3] = '{32'hFFFFFE00, 32'hFFFFFFFF, 9'h000};
    vec_tab[4] = '{32'h00000100, 32'h12345678, 9'h100};
    vec_tab[5] = '{32'h000000AA, 32'h00000000, 9'h0AA};

    rst = 1'b1; wr_en = 1'b0; wr_timestep = '0; wr_batch = '0; wr_data = '0;
    sim_time = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
    spikes_ready = 1'b0; m_start = 1'b0; m_ready = 1'b0;
    prev_done = 1'b0; done_then_idle = 1'b0; valid_seen = 1'b0; last_ts_seen = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_spikes_out", {55'd0, spikes_out}, 64'd0);
    chk("rst_valid", {63'd0, spikes_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_timestep", {56'd0, cur_timestep}, 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven playback of varied bit patterns
    for (int i = 0; i < 6; i++) begin
      wr(8'(i), 1'b0, vec_tab[i].b0);
      wr(8'(i), 1'b1, vec_tab[i].b1);
      exp_q.push_back('{vec_tab[i].spikes, 8'(i)});
    end
    spikes_ready = 1'b1; done_cnt = 0;
    do_start(9'd6, 1'b0);
    run_to_idle("tab_idle", 100);
    chk("tab_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("tab_done_cnt", 64'(done_cnt), 64'd1);

    // Default pattern, latency, done pulse, busy fall
    write_defaults();
    push_defaults(4);
    done_cnt = 0; done_then_idle = 1'b0; prev_done = 1'b0;
    do_start(9'd4, 1'b0);
    n = 0;
    while (!spikes_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'd3);
    run_to_idle("def_idle", 100);
    chk("def_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("def_done_cnt", 64'(done_cnt), 64'd1);
    chk("def_busy_after_done", {63'd0, done_then_idle}, 64'd1);

    // Backpressure at timestep 1
    push_defaults(4);
    spikes_ready = 1'b0;
    do_start(9'd4, 1'b0);
    wait_valid("bp_valid0", 20);
    spikes_ready = 1'b1;
    tick();
    spikes_ready = 1'b0;
    wait_valid("bp_valid1", 20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_spikes", {55'd0, spikes_out}, 64'h021);
      chk("bp_hold_ts", {56'd0, cur_timestep}, 64'd1);
      tick();
    end
    chk("bp_still_valid", {63'd0, spikes_valid}, 64'd1);
    spikes_ready = 1'b1;
    run_to_idle("bp_idle", 100);
    chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Multi-batch vector on the 40-input instance
    wr(8'd0, 1'b0, 32'hFFFFFFFF);
    wr(8'd0, 1'b1, 32'h000000A5);
    sim_time = 9'd1; loop_en = 1'b0; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("mb_latency", 64'(n), 64'd3);
    chk("mb_spikes", {24'd0, m_spikes}, 64'hA5_FFFFFFFF);
    chk("mb_ts", {56'd0, m_ts}, 64'd0);
    $display("multibatch spikes=0x%010h", m_spikes);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("mb_done", {63'd0, m_done}, 64'd1);
    tick(); tick();
    chk("mb_idle", {63'd0, m_busy}, 64'd0);

    // Loop mode, three passes, then abort mid-fetch
    write_defaults();
    push_defaults(2); push_defaults(2); push_defaults(2);
    spikes_ready = 1'b1; done_cnt = 0;
    do_start(9'd2, 1'b1);
    n = 0;
    while (done_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("loop_done_cnt", 64'(done_cnt), 64'd3);
    chk("loop_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();
    chk("loop_refetch_busy", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {63'd0, spikes_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_spikes", {55'd0, spikes_out}, 64'd0);
    tick(); tick(); tick();
    chk("abort_no_done", 64'(done_cnt), 64'd3);

    // sim_time = 0
    valid_seen = 1'b0; done_cnt = 0;
    do_start(9'd0, 1'b0);
    chk("st0_done", {63'd0, done}, 64'd1);
    chk("st0_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("st0_idle", {63'd0, busy}, 64'd0);
    tick();
    chk("st0_done_cnt", 64'(done_cnt), 64'd1);
    chk("st0_no_valid", {63'd0, valid_seen}, 64'd0);

    // start while busy is ignored
    push_defaults(2);
    spikes_ready = 1'b0; done_cnt = 0;
    do_start(9'd2, 1'b0);
    wait_valid("sb_valid", 20);
    sim_time = 9'd5; start = 1'b1;
    tick();
    start = 1'b0;
    spikes_ready = 1'b1;
    run_to_idle("swb_idle", 100);
    tick(); tick();
    chk("swb_stay_idle", {63'd0, busy}, 64'd0);
    chk("swb_done_cnt", 64'(done_cnt), 64'd1);
    chk("swb_sb_empty", 64'(exp_q.size()), 64'd0);

    // Write colliding with the batch-0 read of the fetched timestep
    exp_q.push_back('{9'h1A5, 8'd0});
    do_start(9'd1, 1'b0);
    wr(8'd0, 1'b0, 32'h00000003);
    run_to_idle("coll_idle", 50);
    chk("coll_old_data", 64'(exp_q.size()), 64'd0);
    exp_q.push_back('{9'h003, 8'd0});
    do_start(9'd1, 1'b0);
    run_to_idle("coll_idle2", 50);
    chk("coll_new_data", 64'(exp_q.size()), 64'd0);

    // Full memory: sim_time = 256
    for (int t = 0; t < 256; t++) begin
      w = {4{8'(t)}} ^ 32'h00000155;
      wr(8'(t), 1'b0, w);
      wr(8'(t), 1'b1, 32'hFFFFFFFF);
      exp_q.push_back('{w[8:0], 8'(t)});
    end
    done_cnt = 0;
    do_start(9'd256, 1'b0);
    run_to_idle("full_idle", 2000);
    chk("full_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("full_last_ts", {56'd0, last_ts_seen}, 64'd255);
    chk("full_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset mid-PRESENT, then a fresh replay
    write_defaults();
    push_defaults(4);
    spikes_ready = 1'b0;
    do_start(9'd4, 1'b0);
    wait_valid("ar_valid0", 20);
    spikes_ready = 1'b1;
    tick();
    spikes_ready = 1'b0;
    wait_valid("ar_valid1", 20);
    #2 rst = 1'b1;
    #1;
    chk("ar_spikes", {55'd0, spikes_out}, 64'd0);
    chk("ar_valid", {63'd0, spikes_valid}, 64'd0);
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_timestep", {56'd0, cur_timestep}, 64'd0);
    chk("ar_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    push_defaults(4);
    spikes_ready = 1'b1;
    do_start(9'd4, 1'b0);
    run_to_idle("ar_replay_idle", 100);
    chk("ar_replay_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_pattern_player.md
Name: spike_pattern_player

Overview:
- Multi-batch spike-pattern memory plus playback sequencer. It replaces the single fixed spike-pattern store feeding the SNN core's input layer.
- Config side (driven by the AXI cfg-reg decode) writes per-timestep spike words into batches.
- On start, it replays timesteps 0..sim_time-1. Each timestep's NUM_INPUTS-bit spike vector is presented with a valid/ready handshake to the network.
- Single-shot and loop modes are supported, plus abort.

Parameters:
- NUM_INPUTS, 9: width of the spike vector presented to the network.
- BATCH_WIDTH, 32: bits per stored batch word.
- SPIKE_PATTERN_BATCH_ADDR_WIDTH, 1: batches per timestep NB = 2**value.
- MAX_TIMESTEPS_BITS, 8: timestep address width; memory depth = 2**(MAX_TIMESTEPS_BITS+SPIKE_PATTERN_BATCH_ADDR_WIDTH) words.
- Legal only if NUM_INPUTS <= BATCH_WIDTH*NB (elaboration-time check, $error).

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  memory write strobe
- wr_timestep  in  MAX_TIMESTEPS_BITS  write timestep address
- wr_batch  in  SPIKE_PATTERN_BATCH_ADDR_WIDTH  write batch address
- wr_data  in  BATCH_WIDTH  spike word
- sim_time  in  MAX_TIMESTEPS_BITS+1  number of timesteps to play; sampled on start
- loop_en  in  1  restart at timestep 0 after last; sampled on start
- start  in  1  single-cycle start pulse
- abort  in  1  stop playback
- spikes_out  out  NUM_INPUTS  current timestep spike vector
- spikes_valid  out  1  spikes_out valid
- spikes_ready  in  1  network consumed timestep
- cur_timestep  out  MAX_TIMESTEPS_BITS  timestep currently fetched/presented
- busy  out  1  state != IDLE
- done  out  1  single-cycle pulse at end of each pass

Behaviour:
- Reset: all outputs 0; state IDLE; memory contents undefined (not cleared).
- Bit mapping: input i = batch i/BATCH_WIDTH, bit i%BATCH_WIDTH. Batch bits beyond NUM_INPUTS are ignored.
- Memory: synchronous, 1-cycle read latency, one write port and one read port.
  - Writes are accepted in every state.
  - Same-cycle write/read to the same address returns old data (read-first).
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 latches sim_time/loop_en and clears cur_timestep.
  - Goes to FETCH, or to DONE if sim_time==0.
  - start while busy is ignored.
- FETCH:
  - Issues reads for batches 0..NB-1 on consecutive cycles and captures each return into the assembly register.
  - After the last capture (NB+1 cycles in FETCH), loads spikes_out, sets spikes_valid, goes to PRESENT.
  - Latency start edge -> spikes_valid high = NB+1 cycles.
- PRESENT:
  - Holds spikes_out/spikes_valid stable until spikes_ready=1.
  - On handshake, the same edge drops spikes_valid.
  - If cur_timestep == sim_time-1: go to DONE.
  - Else: cur_timestep+1, go to FETCH.
  - There is no overlap between timesteps: every timestep costs NB+1 fetch cycles plus the handshake cycle(s).
- DONE:
  - done=1 for exactly one cycle.
  - If loop_en and sim_time!=0: cur_timestep=0, go to FETCH.
  - Else go to IDLE.
- sim_time = 2**MAX_TIMESTEPS_BITS is legal (full memory). The final index is 2**MAX_TIMESTEPS_BITS-1, with no cur_timestep wrap before DONE.
- abort has priority over every transition.
  - Next edge: state IDLE, spikes_valid=0, spikes_out=0, no done pulse.
  - abort and start in the same cycle: abort wins; stays IDLE.
- spikes_ready while spikes_valid=0 is ignored.
- Async rst mid-playback returns to IDLE immediately with outputs cleared.

Test Plan:
- Defaults (NB=2). Write timesteps 0..3, batch 0 even = 0x0FA50FA5, odd = 0xF05AF021, batch 1 = 0. sim_time=4, loop_en=0, spikes_ready=1 held. Required: spikes_out sequence 0x1A5, 0x021, 0x1A5, 0x021; first spikes_valid 3 cycles after start; one done pulse; busy falls the cycle after done.
- Backpressure: same pattern, hold spikes_ready=0 for 10 cycles at timestep 1. Required: spikes_out=0x021 and cur_timestep=1 stable throughout; advance only after ready.
- Multi-batch: NUM_INPUTS=40. Timestep 0 batch 0 = 0xFFFFFFFF, batch 1 = 0x000000A5. Required: spikes_out = 0xA5_FFFFFFFF.
- Loop: sim_time=2, loop_en=1, ready=1, run 3 passes, then abort mid-fetch. Required: done pulses every pass; cur_timestep sequence 0,1,0,1,0,1; abort clears spikes_valid next edge with no done.
- Boundaries:
  - sim_time=0: done one cycle after start, spikes_valid never set.
  - sim_time=256: 256 vectors, last cur_timestep=255.
  - start while busy: ignored.
  - Write to the timestep being fetched in the same cycle: old data presented.
- Reset: assert rst mid-PRESENT. Required: all outputs 0 asynchronously; a fresh start then replays from timestep 0.
